imm_extend_pipe: RTL



---
 rtl/imm_extend_pipe_if.sv | 20 ++
 rtl/imm_extend_pipe.sv | 58 +++++
 2 files changed

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: decode-side and execute-side handshake of the immediate pipe
interface imm_extend_pipe_if #(parameter int XLEN = 32);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] instr;
  logic [2:0] ImmSrc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] ImmExt;
  logic illegal;
  modport master (
    output flush, in_valid, instr, ImmSrc, out_ready,
    input in_ready, out_valid, ImmExt, illegal
  );
  modport slave (
    input flush, in_valid, instr, ImmSrc, out_ready,
    output in_ready, out_valid, ImmExt, illegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate extender behind a two-entry skid buffer
module imm_extend_pipe #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  imm_extend_pipe_if.slave bus
);
  logic [XLEN-1:0] imm, m_d, k_d;
  logic ill, m_ill, k_ill, m_v, k_v, acc, m_free;
  always_comb begin
    imm = '0;
    ill = 1'b0;
    case (bus.ImmSrc)
      3'b000: imm = XLEN'($signed(bus.instr[31:20]));
      3'b001: imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
      3'b010: imm = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0}));
      3'b011: imm = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0}));
      3'b100: imm = XLEN'($signed({bus.instr[31:12], 12'b0}));
      3'b101: imm = XLEN'(bus.instr[19:15]);
      3'b110: imm = XLEN == 64 ? XLEN'(bus.instr[25:20]) : XLEN'(bus.instr[24:20]);
      default: ill = 1'b1;
    endcase
  end
  assign acc = bus.in_valid & ~k_v;
  assign m_free = ~m_v | bus.out_ready;
  assign bus.in_ready = ~k_v;
  assign bus.out_valid = m_v;
  assign bus.ImmExt = m_d;
  assign bus.illegal = m_ill;
  // K can only be full while in_ready is low, so a draining K never coincides with an accept
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v <= 1'b0;
      k_v <= 1'b0;
      m_d <= '0;
      m_ill <= 1'b0;
    end else if (bus.flush) begin
      m_v <= 1'b0;
      k_v <= 1'b0;
    end else if (m_free && k_v) begin
      m_v <= 1'b1;
      m_d <= k_d;
      m_ill <= k_ill;
      k_v <= 1'b0;
    end else if (m_free) begin
      m_v <= acc;
      if (acc) begin
        m_d <= imm;
        m_ill <= ill;
      end
    end else if (acc) begin
      k_v <= 1'b1;
      k_d <= imm;
      k_ill <= ill;
    end
  end
endmodule
